// File: rtl/periph_bus_arbiter.sv
// Two-master round-robin arbiter for the shared peripheral Wishbone register bus.
// The grant is held for a whole Wishbone cycle; a watchdog ends stalled accesses with an error.
module periph_bus_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clock,
    input  logic                  reset_n,

    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic [DATA_W/8-1:0]   m0_sel_i,
    input  logic [ADDR_W-1:0]     m0_adr_i,
    input  logic [DATA_W-1:0]     m0_dat_i,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    output logic [DATA_W-1:0]     m0_dat_o,

    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic [DATA_W/8-1:0]   m1_sel_i,
    input  logic [ADDR_W-1:0]     m1_adr_i,
    input  logic [DATA_W-1:0]     m1_dat_i,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic [DATA_W-1:0]     m1_dat_o,

    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [DATA_W/8-1:0]   s_sel_o,
    output logic [ADDR_W-1:0]     s_adr_o,
    output logic [DATA_W-1:0]     s_dat_o,
    input  logic                  s_ack_i,
    input  logic [DATA_W-1:0]     s_dat_i,

    output logic [1:0]            gnt_o,
    output logic                  timeout_irq_o,
    input  logic                  timeout_clr_i
);

    localparam int unsigned SEL_W = DATA_W / 8;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2,
        ERR  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic             last_q,  last_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             irq_q,   irq_d;
    logic             timeout_evt;

    logic m0_req, m1_req;
    assign m0_req = m0_cyc_i & m0_stb_i;
    assign m1_req = m1_cyc_i & m1_stb_i;

    // Inputs of whichever master owns the bus while in a GNT state.
    logic              owner;
    logic              own_cyc, own_stb, own_we;
    logic [SEL_W-1:0]  own_sel;
    logic [ADDR_W-1:0] own_adr;
    logic [DATA_W-1:0] own_dat;

    assign owner   = (state_q == GNT1);
    assign own_cyc = owner ? m1_cyc_i : m0_cyc_i;
    assign own_stb = owner ? m1_stb_i : m0_stb_i;
    assign own_we  = owner ? m1_we_i  : m0_we_i;
    assign own_sel = owner ? m1_sel_i : m0_sel_i;
    assign own_adr = owner ? m1_adr_i : m0_adr_i;
    assign own_dat = owner ? m1_dat_i : m0_dat_i;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin : next_state
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        timeout_evt = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (m0_req && m1_req) begin
                    state_d = last_q ? GNT0 : GNT1;
                end else if (m0_req) begin
                    state_d = GNT0;
                end else if (m1_req) begin
                    state_d = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (!own_cyc) begin
                    state_d = IDLE;
                    last_d  = owner;
                end else if (s_ack_i) begin
                    cnt_d = '0;
                end else if (own_stb) begin
                    if (cnt_q == CNT_LAST) begin
                        // Remember the stalled master in last_q; ERR uses it to route the error.
                        state_d     = ERR;
                        last_d      = owner;
                        cnt_d       = '0;
                        timeout_evt = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ERR: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase

        // A new timeout wins over a clear in the same cycle.
        irq_d = timeout_evt | (irq_q & ~timeout_clr_i);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            irq_q   <= irq_d;
        end
    end

    always_comb begin : outputs
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_dat_o = '0;
        gnt_o    = 2'b00;

        unique case (state_q)
            GNT0, GNT1: begin
                s_cyc_o = own_cyc;
                s_stb_o = own_stb;
                s_we_o  = own_we;
                s_sel_o = own_sel;
                s_adr_o = own_adr;
                s_dat_o = own_dat;
                if (owner) begin
                    gnt_o    = 2'b10;
                    m1_ack_o = s_ack_i & own_cyc;
                    m1_dat_o = s_dat_i;
                end else begin
                    gnt_o    = 2'b01;
                    m0_ack_o = s_ack_i & own_cyc;
                    m0_dat_o = s_dat_i;
                end
            end
            ERR: begin
                if (last_q) begin
                    m1_err_o = 1'b1;
                end else begin
                    m0_err_o = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign timeout_irq_o = irq_q;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Self-checking bench for periph_bus_arbiter: vector table, directed corner cases,
// then randomized traffic compared against a transaction-level reference model.
module tb_periph_bus_arbiter;

    localparam int unsigned TIMEOUT = 8;
    localparam logic [31:0] A0 = 32'h3000_0010;
    localparam logic [31:0] A1 = 32'h3000_0400;
    localparam logic [31:0] D0 = 32'hA5A5_A5A5;
    localparam logic [31:0] D1 = 32'h0BAD_F00D;

    logic clock;
    logic reset_n;

    logic [1:0]       cyc, stb, we;
    logic [1:0][3:0]  sel;
    logic [1:0][31:0] adr, wdat;
    wire  [1:0]       ack_o, err_o;
    wire  [1:0][31:0] rdat_o;

    logic        s_ack;
    logic [31:0] s_rdat;
    logic        clr;
    wire         s_cyc, s_stb, s_we;
    wire  [3:0]  s_sel;
    wire  [31:0] s_adr, s_wdat;
    wire  [1:0]  gnt;
    wire         irq;

    int n_checks = 0;
    int n_fail   = 0;

    periph_bus_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .m0_cyc_i     (cyc[0]),
        .m0_stb_i     (stb[0]),
        .m0_we_i      (we[0]),
        .m0_sel_i     (sel[0]),
        .m0_adr_i     (adr[0]),
        .m0_dat_i     (wdat[0]),
        .m0_ack_o     (ack_o[0]),
        .m0_err_o     (err_o[0]),
        .m0_dat_o     (rdat_o[0]),
        .m1_cyc_i     (cyc[1]),
        .m1_stb_i     (stb[1]),
        .m1_we_i      (we[1]),
        .m1_sel_i     (sel[1]),
        .m1_adr_i     (adr[1]),
        .m1_dat_i     (wdat[1]),
        .m1_ack_o     (ack_o[1]),
        .m1_err_o     (err_o[1]),
        .m1_dat_o     (rdat_o[1]),
        .s_cyc_o      (s_cyc),
        .s_stb_o      (s_stb),
        .s_we_o       (s_we),
        .s_sel_o      (s_sel),
        .s_adr_o      (s_adr),
        .s_dat_o      (s_wdat),
        .s_ack_i      (s_ack),
        .s_dat_i      (s_rdat),
        .gnt_o        (gnt),
        .timeout_irq_o(irq),
        .timeout_clr_i(clr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle_inputs();
        cyc    = 2'b00;
        stb    = 2'b00;
        we     = 2'b01;
        sel[0] = 4'hF;
        sel[1] = 4'h3;
        adr[0] = A0;
        adr[1] = A1;
        wdat[0] = D0;
        wdat[1] = D1;
        s_ack  = 1'b0;
        s_rdat = 32'h0;
        clr    = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    // ---------------- reference model ----------------
    int m_g;      // granted master, -1 when nothing granted
    int m_e;      // master receiving an error this cycle, -1 if none
    int m_last;   // last master served
    int m_stall;  // consecutive unacknowledged strobe cycles in the current grant
    bit m_irq;

    task automatic model_reset();
        m_g = -1; m_e = -1; m_last = 1; m_stall = 0; m_irq = 1'b0;
    endtask

    task automatic model_check();
        logic [1:0]       e_gnt, e_ack, e_err;
        logic [1:0][31:0] e_dat;
        logic             e_cyc, e_stb, e_we;
        logic [3:0]       e_sel;
        logic [31:0]      e_adr, e_wdat;
        e_gnt = 2'b00; e_ack = 2'b00; e_err = 2'b00; e_dat = '0;
        e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_sel = 4'h0; e_adr = 32'h0; e_wdat = 32'h0;
        if (m_g >= 0) begin
            e_gnt[m_g] = 1'b1;
            e_cyc  = cyc[m_g];
            e_stb  = stb[m_g];
            e_we   = we[m_g];
            e_sel  = sel[m_g];
            e_adr  = adr[m_g];
            e_wdat = wdat[m_g];
            e_ack[m_g] = s_ack & cyc[m_g];
            e_dat[m_g] = s_rdat;
        end
        if (m_e >= 0) e_err[m_e] = 1'b1;
        check("rnd_gnt",   32'(gnt),       32'(e_gnt));
        check("rnd_s_cyc", 32'(s_cyc),     32'(e_cyc));
        check("rnd_s_stb", 32'(s_stb),     32'(e_stb));
        check("rnd_s_we",  32'(s_we),      32'(e_we));
        check("rnd_s_sel", 32'(s_sel),     32'(e_sel));
        check("rnd_s_adr", s_adr,          e_adr);
        check("rnd_s_dat", s_wdat,         e_wdat);
        check("rnd_ack",   32'(ack_o),     32'(e_ack));
        check("rnd_err",   32'(err_o),     32'(e_err));
        check("rnd_m0_dat", rdat_o[0],     e_dat[0]);
        check("rnd_m1_dat", rdat_o[1],     e_dat[1]);
        check("rnd_irq",   32'(irq),       32'(m_irq));
    endtask

    task automatic model_advance();
        bit ev;
        ev = 1'b0;
        if (m_e >= 0) begin
            m_e = -1;
        end else if (m_g >= 0) begin
            if (!cyc[m_g]) begin
                m_last = m_g;
                m_g    = -1;
            end else if (s_ack) begin
                m_stall = 0;
            end else if (stb[m_g]) begin
                m_stall++;
                if (m_stall == int'(TIMEOUT)) begin
                    ev     = 1'b1;
                    m_e    = m_g;
                    m_last = m_g;
                    m_g    = -1;
                end
            end
        end else begin
            bit r0, r1;
            r0 = cyc[0] & stb[0];
            r1 = cyc[1] & stb[1];
            if (r0 && r1)  m_g = 1 - m_last;
            else if (r0)   m_g = 0;
            else if (r1)   m_g = 1;
            m_stall = 0;
        end
        m_irq = ev || (m_irq && !clr);
    endtask

    task automatic random_phase(input int cycles, input int ack_div, input int drop_div);
        for (int n = 0; n < cycles; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (cyc[i]) begin
                    if ($urandom_range(drop_div - 1) == 0) cyc[i] = 1'b0;
                end else if ($urandom_range(3) == 0) begin
                    cyc[i] = 1'b1;
                end
                stb[i]  = cyc[i] & ($urandom_range(3) != 0);
                we[i]   = 1'($urandom);
                sel[i]  = 4'($urandom);
                adr[i]  = $urandom;
                wdat[i] = $urandom;
            end
            s_ack  = ($urandom_range(ack_div - 1) == 0);
            s_rdat = $urandom;
            clr    = ($urandom_range(9) == 0);
            settle();
            model_check();
            model_advance();
            tick();
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0]  cyc;
        logic        ack;
        logic [1:0]  gnt;
        logic        s_cyc;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [1:0]  ack_o;
    } vec_t;

    vec_t tbl[13];

    initial begin
        // Tie after reset, single-master accesses, repeated tie.
        tbl[0]  = '{2'b11, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 2'b00};
        tbl[1]  = '{2'b11, 1'b1, 2'b01, 1'b1, A0,    D0,    2'b01};
        tbl[2]  = '{2'b10, 1'b0, 2'b01, 1'b0, A0,    D0,    2'b00};
        tbl[3]  = '{2'b10, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 2'b00};
        tbl[4]  = '{2'b10, 1'b1, 2'b10, 1'b1, A1,    D1,    2'b10};
        tbl[5]  = '{2'b00, 1'b0, 2'b10, 1'b0, A1,    D1,    2'b00};
        tbl[6]  = '{2'b11, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 2'b00};
        tbl[7]  = '{2'b11, 1'b0, 2'b01, 1'b1, A0,    D0,    2'b00};
        tbl[8]  = '{2'b10, 1'b0, 2'b01, 1'b0, A0,    D0,    2'b00};
        tbl[9]  = '{2'b10, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 2'b00};
        tbl[10] = '{2'b10, 1'b0, 2'b10, 1'b1, A1,    D1,    2'b00};
        tbl[11] = '{2'b00, 1'b0, 2'b10, 1'b0, A1,    D1,    2'b00};
        tbl[12] = '{2'b00, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 2'b00};

        idle_inputs();
        reset_n = 1'b0;
        tick();
        settle();
        check("rst_gnt",   32'(gnt),   32'h0);
        check("rst_s_cyc", 32'(s_cyc), 32'h0);
        check("rst_s_stb", 32'(s_stb), 32'h0);
        check("rst_irq",   32'(irq),   32'h0);
        check("rst_err",   32'(err_o), 32'h0);
        tick();
        reset_n = 1'b1;

        for (int r = 0; r < 13; r++) begin
            cyc   = tbl[r].cyc;
            stb   = tbl[r].cyc;
            s_ack = tbl[r].ack;
            settle();
            check($sformatf("tbl%0d_gnt", r),   32'(gnt),   32'(tbl[r].gnt));
            check($sformatf("tbl%0d_s_cyc", r), 32'(s_cyc), 32'(tbl[r].s_cyc));
            check($sformatf("tbl%0d_s_stb", r), 32'(s_stb), 32'(tbl[r].s_cyc));
            check($sformatf("tbl%0d_s_adr", r), s_adr,      tbl[r].adr);
            check($sformatf("tbl%0d_s_dat", r), s_wdat,     tbl[r].wdat);
            check($sformatf("tbl%0d_ack", r),   32'(ack_o), 32'(tbl[r].ack_o));
            tick();
        end

        // Grant hold: m1 keeps cyc for 4 acked strobes while m0 requests throughout.
        do_reset();
        cyc = 2'b10; stb = 2'b10;
        settle();
        tick();
        cyc = 2'b11; stb = 2'b11; s_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            check($sformatf("hold%0d_gnt", i), 32'(gnt),   32'h2);
            check($sformatf("hold%0d_ack", i), 32'(ack_o), 32'h2);
            tick();
        end
        cyc = 2'b01; stb = 2'b01; s_ack = 1'b0;
        settle();
        check("hold_drop_gnt", 32'(gnt),   32'h2);
        check("hold_drop_cyc", 32'(s_cyc), 32'h0);
        tick();
        settle();
        check("hold_idle_gnt", 32'(gnt), 32'h0);
        tick();
        settle();
        check("hold_m0_gnt", 32'(gnt), 32'h1);
        tick();

        // Watchdog: m0 strobes with no ack; error on the (TIMEOUT+1)-th strobe cycle.
        do_reset();
        cyc = 2'b01; stb = 2'b01;
        settle();
        check("to_idle_gnt", 32'(gnt), 32'h0);
        tick();
        for (int k = 1; k <= int'(TIMEOUT); k++) begin
            settle();
            check($sformatf("to_stb%0d", k), 32'(s_stb), 32'h1);
            check($sformatf("to_err%0d", k), 32'(err_o), 32'h0);
            tick();
        end
        settle();
        check("to_err_cycle",   32'(err_o), 32'h1);
        check("to_err_s_cyc",   32'(s_cyc), 32'h0);
        check("to_err_gnt",     32'(gnt),   32'h0);
        check("to_err_irq",     32'(irq),   32'h1);
        tick();
        cyc = 2'b00; stb = 2'b00;
        for (int k = 0; k < 3; k++) begin
            settle();
            check($sformatf("to_sticky%0d", k), 32'(irq),   32'h1);
            check($sformatf("to_noerr%0d", k),  32'(err_o), 32'h0);
            tick();
        end
        clr = 1'b1;
        settle();
        check("to_clr_same_cycle", 32'(irq), 32'h1);
        tick();
        clr = 1'b0;
        settle();
        check("to_cleared", 32'(irq), 32'h0);
        tick();

        // Read data isolation: m1 reads while m0 stays idle.
        do_reset();
        cyc = 2'b10; stb = 2'b10; we = 2'b00; adr[1] = 32'h0000_1000;
        s_rdat = 32'hDEAD_BEEF;
        settle();
        check("rd_idle_m0_dat", rdat_o[0], 32'h0);
        tick();
        settle();
        check("rd_wait_ack",    32'(ack_o), 32'h0);
        check("rd_wait_m0_dat", rdat_o[0],  32'h0);
        tick();
        s_ack = 1'b1; s_rdat = 32'h0000_1234;
        settle();
        check("rd_m1_dat",   rdat_o[1],  32'h0000_1234);
        check("rd_m1_ack",   32'(ack_o), 32'h2);
        check("rd_m0_dat",   rdat_o[0],  32'h0);
        check("rd_s_we",     32'(s_we),  32'h0);
        tick();
        idle_inputs();
        tick();

        // Asynchronous reset in the middle of an acked m0 access.
        do_reset();
        cyc = 2'b01; stb = 2'b01;
        tick();
        s_ack = 1'b1;
        #1;
        check("rm_pre_gnt", 32'(gnt),   32'h1);
        check("rm_pre_ack", 32'(ack_o), 32'h1);
        reset_n = 1'b0;
        #1;
        check("rm_gnt",   32'(gnt),   32'h0);
        check("rm_s_cyc", 32'(s_cyc), 32'h0);
        check("rm_s_stb", 32'(s_stb), 32'h0);
        check("rm_s_adr", s_adr,      32'h0);
        check("rm_ack",   32'(ack_o), 32'h0);
        check("rm_dat0",  rdat_o[0],  32'h0);
        tick();
        reset_n = 1'b1;
        s_ack = 1'b0;
        cyc = 2'b11; stb = 2'b11;
        settle();
        check("rm_post_idle", 32'(gnt), 32'h0);
        tick();
        settle();
        check("rm_post_tie", 32'(gnt), 32'h1);
        tick();

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        random_phase(600, 2, 6);
        random_phase(600, 16, 24);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
